seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed scan driver for the 4-digit seven-segment display.
- Sits directly downstream of the dec/oct display selector and consumes its four 7-bit segment words (seven_Display1..4).
- Drives one shared segment bus plus four digit enables, lighting one digit at a time.
- Inserts a blanking dead time between digits to prevent ghosting, and snapshots all four words once per frame so the display cannot tear.

Parameters:
- DIV, 50000, clock cycles per digit slot; legal range is DIV ≥ 2.
- DEAD, 500, blank cycles at the start of each slot; legal range is 1 ≤ DEAD < DIV.
- SEG_ACTIVE_LOW, 1, 1 means seg_out is inverted (common-anode).
- DIG_ACTIVE_LOW, 1, 1 means dig_en is inverted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 turns the display fully off
- seven_Display1  in  7  digit 1 (rightmost) segments, active-high, bit0=a … bit6=g
- seven_Display2  in  7  digit 2 segments
- seven_Display3  in  7  digit 3 segments
- seven_Display4  in  7  digit 4 (leftmost) segments
- seg_out  out  7  shared segment bus (polarity set by SEG_ACTIVE_LOW)
- dig_en  out  4  digit enables, bit0 = digit 1 (polarity set by DIG_ACTIVE_LOW)
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Clock and reset: single clock domain on clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, cnt = 0, idx = 0, snapshot = 0.
  - seg_out = all segments off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
  - dig_en = all digits off (4'hF if DIG_ACTIVE_LOW, else 4'h0).
  - frame_start = 0.
- Output timing: all outputs are registers updated on the same edge as the state, so there is no combinational path from inputs to outputs.
- State machine (state, cnt in 0..DIV-1, idx in 0..3):
  - IDLE: all outputs off, cnt = 0, idx = 0. When en is sampled 1 → BLANK, cnt = 0, idx = 0, all four inputs captured into the snapshot, frame_start = 1 for that cycle.
  - BLANK: digits and segments off, cnt increments. On the edge where cnt reaches DEAD → SHOW, dig_en[idx] active, seg_out = snapshot[idx] (after polarity).
  - SHOW: outputs held, cnt increments. On the edge after cnt = DIV-1 → BLANK with cnt = 0 and idx = idx+1 mod 4. When idx wraps from 3 to 0, a new snapshot is taken and frame_start pulses.
- Scan order and timing:
  - Digits scan 1→2→3→4, then repeat.
  - Frame length is 4·DIV cycles.
  - Each digit is lit for DIV-DEAD cycles.
- Enable handling: en sampled 0 in any state → IDLE on the next edge; outputs are off from that edge onward and cnt/idx are cleared. Re-enabling restarts at digit 1 with a fresh snapshot.
- Exclusivity: at most one dig_en bit is ever active. Whenever no digit is enabled, the segment bus shows all segments off.
- Input changes mid-frame are ignored until the next frame boundary.
- Asynchronous reset asserted mid-slot forces the reset values immediately, independent of clk.

Decomposition:
- Package seg_pkg holds:
  - typedef seg_t = logic [6:0]
  - localparam NUM_DIGITS = 4
  - SEG_OFF_AH = 7'h00
  - typedef enum {IDLE, BLANK, SHOW} scan_state_t
- Sub-module seg_slot_timer: cnt counter 0..DIV-1 with synchronous clear, emitting pulses at_dead (cnt = DEAD-1) and at_end (cnt = DIV-1). The FSM, snapshot register and output registers stay in the top module.

Test Plan (DIV=8, DEAD=2, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1):
- Reset: hold rst_n=0 → seg_out=7'h7F, dig_en=4'hF, frame_start=0. Release with en=0 → outputs unchanged indefinitely.
- Basic scan: inputs 7'h06, 7'h5B, 7'h4F, 7'h66, then en=1 → frame_start pulses 1 cycle; 2 blank cycles; dig_en=4'hE with seg_out=~7'h06 for 6 cycles; then 4'hD/~7'h5B, 4'hB/~7'h4F, 4'h7/~7'h66. Next frame_start pulses exactly 32 cycles after the first.
- Snapshot: change seven_Display3 to 7'h7F while digit 2 is lit → digit 3 still shows ~7'h4F this frame and shows ~7'h7F (=7'h00) in the next frame.
- Enable drop: en=0 mid-SHOW of digit 3 → next edge seg_out=7'h7F, dig_en=4'hF. Re-assert en → frame_start pulses and the scan restarts at digit 1 after 2 blank cycles.
- Async reset: pulse rst_n low between clock edges during SHOW → outputs return to reset values immediately, before the next clk edge.
- Polarity: rerun basic scan with both polarity parameters = 0 → dig_en=4'h1 with seg_out=7'h06; blank shows seg_out=7'h00, dig_en=4'h0. Across all runs, assert that at most one digit is ever active.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   seg_t        : one 7-bit segment word, bit0 = a ... bit6 = g
//   NUM_DIGITS   : number of multiplexed digits
//   SEG_OFF_AH   : "all segments off" in active-high form
//   scan_state_t : scan FSM states
//   seg_polarity : applies the board polarity to an active-high word
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int   NUM_DIGITS = 4;
  localparam seg_t SEG_OFF_AH = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  function automatic seg_t seg_polarity(input seg_t s, input bit active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/seg_scan_driver_timer.sv
// Slot timer for the scan driver: counts 0..DIV-1 and wraps.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : synchronous clear, forces cnt to 0 on the next edge
//   o_at_dead   : high while cnt = DEAD-1 (last blank cycle of the slot)
//   o_at_end    : high while cnt = DIV-1 (last cycle of the slot)
module seg_slot_timer #(
  parameter int DIV  = 50000,
  parameter int DEAD = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_at_dead,
  output logic o_at_end
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DEAD_M1 = CW'(DEAD - 1);
  localparam logic [CW-1:0] END_V   = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == END_V)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_dead = (r_cnt == DEAD_M1);
  assign o_at_end  = (r_cnt == END_V);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver.
// One digit is lit at a time; every slot starts with DEAD blank cycles to
// avoid ghosting, and all four input words are snapshotted once per frame
// so a frame never mixes old and new values.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : scan enable; 0 blanks the display and resets the scan
//   seven_Display1..4   : active-high segment words, 1 = rightmost digit
//   seg_out             : shared segment bus (polarity by SEG_ACTIVE_LOW)
//   dig_en              : digit enables, bit0 = digit 1 (polarity by DIG_ACTIVE_LOW)
//   frame_start         : one-cycle pulse when a new snapshot is taken
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV            = 50000,
  parameter int DEAD           = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seven_Display1,
  input  logic [6:0] seven_Display2,
  input  logic [6:0] seven_Display3,
  input  logic [6:0] seven_Display4,
  output logic [6:0] seg_out,
  output logic [3:0] dig_en,
  output logic       frame_start
);

  localparam seg_t       SEG_OFF = seg_polarity(SEG_OFF_AH, SEG_ACTIVE_LOW);
  localparam logic [3:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  scan_state_t r_state, w_state_next;
  logic [1:0]  r_idx, w_idx_next;
  seg_t        r_snap [NUM_DIGITS];
  seg_t        w_inputs [NUM_DIGITS];
  logic        w_snap_load;
  logic        w_fs_next;
  seg_t        r_seg, w_seg_next;
  logic [3:0]  r_dig, w_dig_next;
  logic        r_fs;
  logic        w_clr;
  logic        w_at_dead;
  logic        w_at_end;
  logic [3:0]  w_dig_onehot;

  assign w_inputs[0] = seven_Display1;
  assign w_inputs[1] = seven_Display2;
  assign w_inputs[2] = seven_Display3;
  assign w_inputs[3] = seven_Display4;

  // The counter restarts at 0 on the edge that leaves IDLE and whenever
  // the scan is being shut down.
  assign w_clr = (r_state == IDLE) || !en;

  seg_slot_timer #(
    .DIV  (DIV),
    .DEAD (DEAD)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .o_at_dead (w_at_dead),
    .o_at_end  (w_at_end)
  );

  assign w_dig_onehot = 4'b0001 << r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_seg   <= SEG_OFF;
      r_dig   <= DIG_OFF;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_seg   <= w_seg_next;
      r_dig   <= w_dig_next;
      r_fs    <= w_fs_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= SEG_OFF_AH;
    end else if (w_snap_load) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= w_inputs[i];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_snap_load  = 1'b0;
    w_fs_next    = 1'b0;
    if (!en) begin
      w_state_next = IDLE;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = BLANK;
          w_idx_next   = '0;
          w_snap_load  = 1'b1;
          w_fs_next    = 1'b1;
        end
        BLANK: begin
          if (w_at_dead) w_state_next = SHOW;
        end
        SHOW: begin
          if (w_at_end) begin
            w_state_next = BLANK;
            w_idx_next   = r_idx + 2'd1;
            // Frame boundary: take the next snapshot as digit 4 ends.
            if (r_idx == 2'd3) begin
              w_snap_load = 1'b1;
              w_fs_next   = 1'b1;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
          w_idx_next   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they change on the same edge.
    // r_idx is already the lit digit whenever the next state is SHOW.
    w_seg_next = SEG_OFF;
    w_dig_next = DIG_OFF;
    if (w_state_next == SHOW) begin
      w_seg_next = seg_polarity(r_snap[r_idx], SEG_ACTIVE_LOW);
      w_dig_next = w_dig_onehot ^ DIG_OFF;
    end
  end

  assign seg_out     = r_seg;
  assign dig_en      = r_dig;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] d1 = 7'h00, d2 = 7'h00, d3 = 7'h00, d4 = 7'h00;
  logic [6:0] seg_al, seg_ah;
  logic [3:0] dig_al, dig_ah;
  logic       fs_al, fs_ah;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIV(8), .DEAD(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .seven_Display1(d1), .seven_Display2(d2), .seven_Display3(d3), .seven_Display4(d4),
    .seg_out(seg_al), .dig_en(dig_al), .frame_start(fs_al)
  );

  seg_scan_driver #(.DIV(8), .DEAD(2), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .en(en),
    .seven_Display1(d1), .seven_Display2(d2), .seven_Display3(d3), .seven_Display4(d4),
    .seg_out(seg_ah), .dig_en(dig_ah), .frame_start(fs_ah)
  );

  // Cycle c = 1 is the first cycle after the edge that samples en=1.
  // Each 8-cycle slot: 2 blank cycles, then 6 lit cycles.
  function automatic int slot_of(input int c);
    return ((c - 1) / 8) % 4;
  endfunction

  function automatic bit lit_at(input int c);
    return ((c - 1) % 8) >= 2;
  endfunction

  // Exclusivity and blank-bus rule, checked on every falling edge.
  always @(negedge clk) begin
    n_checks++;
    if ($countones(~dig_al) > 1 || $countones(dig_ah) > 1 ||
        (dig_al === 4'hF && seg_al !== 7'h7F) || (dig_ah === 4'h0 && seg_ah !== 7'h00)) begin
      $display("FAIL exclusivity t=%0t dig_al=%h seg_al=%h dig_ah=%h seg_ah=%h",
               $time, dig_al, seg_al, dig_ah, seg_ah);
    end else begin
      n_pass++;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (seg_al !== 7'h7F || dig_al !== 4'hF || fs_al !== 1'b0)
      $display("FAIL reset_hold seg=%h dig=%h fs=%b expected 7f f 0", seg_al, dig_al, fs_al);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (seg_al !== 7'h7F || dig_al !== 4'hF || fs_al !== 1'b0 ||
          seg_ah !== 7'h00 || dig_ah !== 4'h0 || fs_ah !== 1'b0)
        $display("FAIL reset_idle cyc=%0d seg=%h dig=%h fs=%b expected 7f f 0", i, seg_al, dig_al, fs_al);
      else n_pass++;
    end
    $display("test_reset done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_basic_scan();
    logic [6:0] fv [4];
    logic [6:0] exp_seg;
    logic [3:0] exp_dig, oh;
    logic       exp_fs;
    int d;
    apply_reset();
    d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; d4 = 7'h66;
    fv[0] = 7'h06; fv[1] = 7'h5B; fv[2] = 7'h4F; fv[3] = 7'h66;
    en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      d       = slot_of(c);
      oh      = 4'b0001 << d;
      exp_dig = lit_at(c) ? ~oh : 4'hF;
      exp_seg = lit_at(c) ? ~fv[d] : 7'h7F;
      exp_fs  = (c == 1) || (c == 33);
      n_checks++;
      if (dig_al !== exp_dig || seg_al !== exp_seg || fs_al !== exp_fs)
        $display("FAIL basic_scan c=%0d dig=%h seg=%h fs=%b expected %h %h %b",
                 c, dig_al, seg_al, fs_al, exp_dig, exp_seg, exp_fs);
      else n_pass++;
    end
    $display("test_basic_scan done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_snapshot();
    logic [6:0] fv [4];
    logic [6:0] exp_seg;
    logic [3:0] exp_dig, oh;
    logic       exp_fs;
    int d;
    apply_reset();
    d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; d4 = 7'h66;
    fv[0] = 7'h06; fv[1] = 7'h5B; fv[2] = 7'h4F; fv[3] = 7'h66;
    en = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 33) fv[2] = 7'h7F;  // new frame picks up the changed digit 3
      d       = slot_of(c);
      oh      = 4'b0001 << d;
      exp_dig = lit_at(c) ? ~oh : 4'hF;
      exp_seg = lit_at(c) ? ~fv[d] : 7'h7F;
      exp_fs  = (c == 1) || (c == 33);
      n_checks++;
      if (dig_al !== exp_dig || seg_al !== exp_seg || fs_al !== exp_fs)
        $display("FAIL snapshot c=%0d dig=%h seg=%h fs=%b expected %h %h %b",
                 c, dig_al, seg_al, fs_al, exp_dig, exp_seg, exp_fs);
      else n_pass++;
      if (c == 12) d3 = 7'h7F;     // digit 2 is lit here
    end
    $display("test_snapshot done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_enable_drop();
    logic [6:0] fv [4];
    logic [6:0] exp_seg;
    logic [3:0] exp_dig, oh;
    logic       exp_fs;
    int d;
    apply_reset();
    d1 = 7'h3F; d2 = 7'h06; d3 = 7'h5B; d4 = 7'h4F;
    fv[0] = 7'h3F; fv[1] = 7'h06; fv[2] = 7'h5B; fv[3] = 7'h4F;
    en = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (dig_al !== 4'hB || seg_al !== ~7'h5B)
      $display("FAIL drop_pre dig=%h seg=%h expected b %h", dig_al, seg_al, ~7'h5B);
    else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (seg_al !== 7'h7F || dig_al !== 4'hF || fs_al !== 1'b0)
        $display("FAIL drop_off cyc=%0d seg=%h dig=%h fs=%b expected 7f f 0", i, seg_al, dig_al, fs_al);
      else n_pass++;
    end
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      d       = slot_of(c);
      oh      = 4'b0001 << d;
      exp_dig = lit_at(c) ? ~oh : 4'hF;
      exp_seg = lit_at(c) ? ~fv[d] : 7'h7F;
      exp_fs  = (c == 1);
      n_checks++;
      if (dig_al !== exp_dig || seg_al !== exp_seg || fs_al !== exp_fs)
        $display("FAIL restart c=%0d dig=%h seg=%h fs=%b expected %h %h %b",
                 c, dig_al, seg_al, fs_al, exp_dig, exp_seg, exp_fs);
      else n_pass++;
    end
    $display("test_enable_drop done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_async_reset();
    apply_reset();
    d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; d4 = 7'h66;
    en = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (dig_al !== 4'hE || seg_al !== ~7'h06)
      $display("FAIL async_pre dig=%h seg=%h expected e %h", dig_al, seg_al, ~7'h06);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (seg_al !== 7'h7F || dig_al !== 4'hF || fs_al !== 1'b0 ||
        seg_ah !== 7'h00 || dig_ah !== 4'h0)
      $display("FAIL async_reset seg=%h dig=%h fs=%b expected 7f f 0", seg_al, dig_al, fs_al);
    else n_pass++;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_async_reset done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_polarity();
    logic [6:0] fv [4];
    logic [6:0] exp_seg;
    logic [3:0] exp_dig;
    logic       exp_fs;
    int d;
    apply_reset();
    d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; d4 = 7'h66;
    fv[0] = 7'h06; fv[1] = 7'h5B; fv[2] = 7'h4F; fv[3] = 7'h66;
    en = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      d       = slot_of(c);
      exp_dig = lit_at(c) ? (4'b0001 << d) : 4'h0;
      exp_seg = lit_at(c) ? fv[d] : 7'h00;
      exp_fs  = (c == 1) || (c == 33);
      n_checks++;
      if (dig_ah !== exp_dig || seg_ah !== exp_seg || fs_ah !== exp_fs)
        $display("FAIL polarity c=%0d dig=%h seg=%h fs=%b expected %h %h %b",
                 c, dig_ah, seg_ah, fs_ah, exp_dig, exp_seg, exp_fs);
      else n_pass++;
    end
    en = 1'b0;
    $display("test_polarity done: %0d/%0d", n_pass, n_checks);
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_enable_drop();
    test_async_reset();
    test_polarity();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
